// File: rtl/ldvio_pkg.sv
// Shared types and default sizing for the load-violation report queue.
package ldvio_pkg;

    localparam int LDVIO_NREPORT = 2;
    localparam int LDVIO_DEPTH   = 8;
    localparam int LDVIO_INDEX   = 7;
    localparam int LDVIO_WIDTH   = 8;

    typedef struct packed {
        logic [LDVIO_INDEX-1:0] addr;
        logic [LDVIO_WIDTH-1:0] data;
    } ldvio_rpt_t;

endpackage

// File: rtl/ldvio_compact.sv
// Combinational valid-compaction network: valid report ports are packed into
// the lowest slots in ascending port order, with the number of packed slots.
module ldvio_compact
    import ldvio_pkg::*;
#(
    parameter int NREPORT = LDVIO_NREPORT,
    parameter int INDEX   = LDVIO_INDEX,
    parameter int WIDTH   = LDVIO_WIDTH
) (
    input  logic [NREPORT-1:0]         valid,
    input  logic [NREPORT*INDEX-1:0]   addr,
    input  logic [NREPORT*WIDTH-1:0]   data,
    output logic [NREPORT*INDEX-1:0]   slot_addr,
    output logic [NREPORT*WIDTH-1:0]   slot_data,
    output logic [$clog2(NREPORT+1)-1:0] count
);

    localparam int CNT_W = $clog2(NREPORT + 1);

    // A valid port lands in the slot numbered by how many valid ports sit below it.
    always_comb begin
        int n;
        n         = 32'sd0;
        slot_addr = '0;
        slot_data = '0;
        for (int k = 0; k < NREPORT; k++) begin
            if (valid[k]) begin
                for (int j = 0; j < NREPORT; j++) begin
                    if (j == n) begin
                        slot_addr[j*INDEX +: INDEX] = addr[k*INDEX +: INDEX];
                        slot_data[j*WIDTH +: WIDTH] = data[k*WIDTH +: WIDTH];
                    end else begin
                        slot_addr[j*INDEX +: INDEX] = slot_addr[j*INDEX +: INDEX];
                    end
                end
                n = n + 32'sd1;
            end else begin
                n = n;
            end
        end
        count = CNT_W'(n);
    end

endmodule

// File: rtl/ldvio_report_queue.sv
// Load-violation report queue: buffers up to NREPORT reports per cycle and
// drains one per cycle into the RAM write port. Optional LDVIO_BYPASS_EN lets
// port 0 write straight through when the queue is empty.
module ldvio_report_queue
    import ldvio_pkg::*;
#(
    parameter int NREPORT = LDVIO_NREPORT,
    parameter int DEPTH   = LDVIO_DEPTH,
    parameter int INDEX   = LDVIO_INDEX,
    parameter int WIDTH   = LDVIO_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NREPORT-1:0]         rpt_valid_i,
    input  logic [NREPORT*INDEX-1:0]   rpt_addr_i,
    input  logic [NREPORT*WIDTH-1:0]   rpt_data_i,
    output logic                       rpt_ready_o,
    input  logic                       flush_i,
    input  logic                       stall_i,
    output logic [INDEX-1:0]           addr0wr_o,
    output logic [WIDTH-1:0]           data0wr_o,
    output logic                       we0_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AW = $clog2(NREPORT + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - NREPORT);

    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic [INDEX-1:0] mem_addr_r [DEPTH];
    logic [WIDTH-1:0] mem_data_r [DEPTH];

    logic                     ready_s;
    logic                     nonempty_s;
    logic                     pop_s;
    logic                     accept_s;
    logic                     bypass_s;
    logic [NREPORT-1:0]       enq_valid_s;
    logic [NREPORT*INDEX-1:0] slot_addr_s;
    logic [NREPORT*WIDTH-1:0] slot_data_s;
    logic [AW-1:0]            slot_cnt_s;
    logic [AW-1:0]            acc_cnt_s;

    // Capacity uses the pre-pop occupancy; a same-cycle pop gives no credit.
    assign ready_s    = (count_r <= READY_MAX);
    assign nonempty_s = (count_r != {CW{1'b0}});
    assign pop_s      = nonempty_s & ~stall_i & ~flush_i;
    assign accept_s   = ready_s & ~flush_i;

`ifdef LDVIO_BYPASS_EN
    assign bypass_s = ~nonempty_s & ~stall_i & ~flush_i & rpt_valid_i[0];
`else
    assign bypass_s = 1'b0;
`endif

    // A bypassed port 0 is written directly and must not also be queued.
    assign enq_valid_s = rpt_valid_i & ~NREPORT'(bypass_s);

    ldvio_compact #(
        .NREPORT (NREPORT),
        .INDEX   (INDEX),
        .WIDTH   (WIDTH)
    ) u_compact (
        .valid     (enq_valid_s),
        .addr      (rpt_addr_i),
        .data      (rpt_data_i),
        .slot_addr (slot_addr_s),
        .slot_data (slot_data_s),
        .count     (slot_cnt_s)
    );

    assign acc_cnt_s = accept_s ? slot_cnt_s : {AW{1'b0}};

    // Write-port data: bypassed report, else head entry, masked to zero when empty.
    always_comb begin
        if (bypass_s) begin
            addr0wr_o = rpt_addr_i[INDEX-1:0];
            data0wr_o = rpt_data_i[WIDTH-1:0];
        end else if (nonempty_s) begin
            addr0wr_o = mem_addr_r[head_r];
            data0wr_o = mem_data_r[head_r];
        end else begin
            addr0wr_o = {INDEX{1'b0}};
            data0wr_o = {WIDTH{1'b0}};
        end
    end

    assign we0_o       = pop_s | bypass_s;
    assign rpt_ready_o = ready_s;
    assign count_o     = count_r;
    assign overflow_o  = overflow_r;

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush_i) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (pop_s) begin
                head_r <= head_r + PW'(1'b1);
            end else begin
                head_r <= head_r;
            end
            tail_r  <= tail_r + PW'(acc_cnt_s);
            count_r <= count_r + CW'(acc_cnt_s) - CW'(pop_s);
            if (!ready_s && (rpt_valid_i != {NREPORT{1'b0}})) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Entry storage; contents are only observed while the slot is occupied.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int j = 0; j < NREPORT; j++) begin
                if (j < int'(acc_cnt_s)) begin
                    mem_addr_r[tail_r + PW'(j)] <= slot_addr_s[j*INDEX +: INDEX];
                    mem_data_r[tail_r + PW'(j)] <= slot_data_s[j*WIDTH +: WIDTH];
                end else begin
                    mem_addr_r[tail_r + PW'(j)] <= mem_addr_r[tail_r + PW'(j)];
                    mem_data_r[tail_r + PW'(j)] <= mem_data_r[tail_r + PW'(j)];
                end
            end
        end else begin
            mem_addr_r[head_r] <= mem_addr_r[head_r];
            mem_data_r[head_r] <= mem_data_r[head_r];
        end
    end

endmodule

// File: tb/tb_ldvio_report_queue.sv
// Self-checking bench for ldvio_report_queue against a queue-based reference model.
`timescale 1ns/1ps
module tb_ldvio_report_queue;
    import ldvio_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] cv = 2'b00;
    logic [6:0] ca0 = 7'h00, ca1 = 7'h00;
    logic [7:0] cd0 = 8'h00, cd1 = 8'h00;
    logic       cfl = 1'b0, cst = 1'b0;

    logic       rpt_ready_o, we0_o, overflow_o;
    logic [6:0] addr0wr_o;
    logic [7:0] data0wr_o;
    logic [3:0] count_o;

    int checks = 0;
    int failures = 0;

    ldvio_rpt_t mq[$];
    bit         movf = 1'b0;
    bit         pending = 1'b0;
    bit         e_ready, e_we;
    logic [6:0] e_addr;
    logic [7:0] e_data;
    int         e_count;

    ldvio_report_queue dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rpt_valid_i (cv),
        .rpt_addr_i  ({ca1, ca0}),
        .rpt_data_i  ({cd1, cd0}),
        .rpt_ready_o (rpt_ready_o),
        .flush_i     (cfl),
        .stall_i     (cst),
        .addr0wr_o   (addr0wr_o),
        .data0wr_o   (data0wr_o),
        .we0_o       (we0_o),
        .count_o     (count_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    function automatic bit model_bypass();
`ifdef LDVIO_BYPASS_EN
        return (mq.size() == 0) && !cst && !cfl && cv[0];
`else
        return 1'b0;
`endif
    endfunction

    // Apply one clock edge's worth of spec behaviour to the model.
    task automatic model_update();
        bit byp, rdy;
        byp = model_bypass();
        rdy = (LDVIO_DEPTH - mq.size()) >= LDVIO_NREPORT;
        if (cfl) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && !cst) void'(mq.pop_front());
            if (rdy) begin
                if (cv[0] && !byp) mq.push_back('{addr: ca0, data: cd0});
                if (cv[1]) mq.push_back('{addr: ca1, data: cd1});
            end else if (cv != 2'b00) begin
                movf = 1'b1;
            end
        end
    endtask

    task automatic model_expect();
        bit byp;
        byp     = model_bypass();
        e_ready = (LDVIO_DEPTH - mq.size()) >= LDVIO_NREPORT;
        e_we    = byp || (mq.size() != 0 && !cst && !cfl);
        e_count = mq.size();
        if (byp) begin
            e_addr = ca0; e_data = cd0;
        end else if (mq.size() != 0) begin
            e_addr = mq[0].addr; e_data = mq[0].data;
        end else begin
            e_addr = 7'h00; e_data = 8'h00;
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [6:0] a0, input logic [6:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1, input logic fl, input logic st);
        @(negedge clk);
        if (pending) model_update();
        pending = 1'b1;
        cv = v; ca0 = a0; ca1 = a1; cd0 = d0; cd1 = d1; cfl = fl; cst = st;
        #1;
        model_expect();
    endtask

    task automatic drive_idle();
        drive(2'b00, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cv = 2'b00; cfl = 1'b0; cst = 1'b0;
        mq.delete(); movf = 1'b0; pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (we0_o !== 1'b0) begin failures++; $display("FAIL reset_we0 got=%b exp=0", we0_o); end
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (rpt_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rpt_ready_o); end
        checks++; if ({addr0wr_o, data0wr_o, overflow_o} !== 16'h0000) begin failures++;
            $display("FAIL reset_outs got=%h/%h/%b exp=0/0/0", addr0wr_o, data0wr_o, overflow_o); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_idle();
            checks++; if (we0_o !== 1'b0) begin failures++; $display("FAIL idle_we0 got=%b exp=0", we0_o); end
            checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL idle_count got=%0d exp=0", count_o); end
            checks++; if (rpt_ready_o !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", rpt_ready_o); end
            checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL idle_ovf got=%b exp=0", overflow_o); end
        end
    endtask

    task automatic test_single();
        drive(2'b01, 7'h15, 7'h00, 8'h01, 8'h00, 1'b0, 1'b0);
        checks++; if (we0_o !== e_we) begin failures++; $display("FAIL single0_we0 got=%b exp=%b", we0_o, e_we); end
        drive_idle();
`ifndef LDVIO_BYPASS_EN
        checks++; if ({we0_o, addr0wr_o, data0wr_o} !== {1'b1, 7'h15, 8'h01}) begin failures++;
            $display("FAIL single1_write got=%b/%h/%h exp=1/15/01", we0_o, addr0wr_o, data0wr_o); end
        checks++; if (count_o !== 4'd1) begin failures++; $display("FAIL single1_count got=%0d exp=1", count_o); end
`endif
        drive_idle();
        checks++; if (count_o !== 4'd0) begin failures++; $display("FAIL single2_count got=%0d exp=0", count_o); end
        checks++; if (we0_o !== 1'b0) begin failures++; $display("FAIL single2_we0 got=%b exp=0", we0_o); end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 14; i++) begin
            if (i < 5) drive(2'b11, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
            else drive_idle();
            if (i == 4) begin
                checks++; if ({count_o, rpt_ready_o} !== {4'd8, 1'b0}) begin failures++;
                    $display("FAIL burst_full got=%0d/%b exp=8/0", count_o, rpt_ready_o); end
            end
            if (i == 5) begin
                checks++; if ({count_o, overflow_o} !== {4'd8, 1'b1}) begin failures++;
                    $display("FAIL burst_ovf got=%0d/%b exp=8/1", count_o, overflow_o); end
            end
            checks++; if (we0_o !== e_we) begin failures++; $display("FAIL burst_we0 cyc=%0d got=%b exp=%b", i, we0_o, e_we); end
            checks++; if ({addr0wr_o, data0wr_o} !== {e_addr, e_data}) begin failures++;
                $display("FAIL burst_wdata cyc=%0d got=%h/%h exp=%h/%h", i, addr0wr_o, data0wr_o, e_addr, e_data); end
            checks++; if (int'(count_o) !== e_count) begin failures++; $display("FAIL burst_count cyc=%0d got=%0d exp=%0d", i, count_o, e_count); end
            checks++; if ({rpt_ready_o, overflow_o} !== {e_ready, movf}) begin failures++;
                $display("FAIL burst_flags cyc=%0d got=%b/%b exp=%b/%b", i, rpt_ready_o, overflow_o, e_ready, movf); end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 21; i++) begin
            if (i < 20) drive((i % 2 == 0) ? 2'b10 : 2'b01, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
            else drive_idle();
            checks++; if (count_o > 4'd1) begin failures++; $display("FAIL wrap_count_bound cyc=%0d got=%0d exp<=1", i, count_o); end
            checks++; if (we0_o !== e_we) begin failures++; $display("FAIL wrap_we0 cyc=%0d got=%b exp=%b", i, we0_o, e_we); end
            checks++; if ({addr0wr_o, data0wr_o} !== {e_addr, e_data}) begin failures++;
                $display("FAIL wrap_wdata cyc=%0d got=%h/%h exp=%h/%h", i, addr0wr_o, data0wr_o, e_addr, e_data); end
        end
    endtask

    task automatic test_flush();
        drive(2'b11, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        drive(2'b11, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        drive(2'b01, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        drive(2'b11, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        checks++; if ({count_o, we0_o} !== {4'd5, 1'b0}) begin failures++;
            $display("FAIL flush_cycle got=%0d/%b exp=5/0", count_o, we0_o); end
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            checks++; if ({count_o, we0_o} !== {4'd0, 1'b0}) begin failures++;
                $display("FAIL flush_after cyc=%0d got=%0d/%b exp=0/0", i, count_o, we0_o); end
        end
    endtask

`ifdef LDVIO_BYPASS_EN
    task automatic test_bypass();
        drive(2'b11, 7'h03, 7'h04, 8'hA3, 8'hA4, 1'b0, 1'b0);
        checks++; if ({we0_o, addr0wr_o, data0wr_o} !== {1'b1, 7'h03, 8'hA3}) begin failures++;
            $display("FAIL bypass_now got=%b/%h/%h exp=1/03/a3", we0_o, addr0wr_o, data0wr_o); end
        drive_idle();
        checks++; if ({we0_o, addr0wr_o, data0wr_o} !== {1'b1, 7'h04, 8'hA4}) begin failures++;
            $display("FAIL bypass_next got=%b/%h/%h exp=1/04/a4", we0_o, addr0wr_o, data0wr_o); end
    endtask
`endif

    task automatic test_reset_mid();
        drive(2'b11, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        drive(2'b11, 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        cv = 2'b00; cfl = 1'b0; cst = 1'b0;
        mq.delete(); movf = 1'b0; pending = 1'b0;
        #1;
        checks++; if ({count_o, we0_o, overflow_o} !== {4'd0, 1'b0, 1'b0}) begin failures++;
            $display("FAIL midreset got=%0d/%b/%b exp=0/0/0", count_o, we0_o, overflow_o); end
        @(negedge clk);
        reset_n = 1'b1;
        drive_idle();
        checks++; if ({count_o, we0_o} !== {4'd0, 1'b0}) begin failures++;
            $display("FAIL midreset_after got=%0d/%b exp=0/0", count_o, we0_o); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), 7'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 4));
            checks++; if (we0_o !== e_we) begin failures++; $display("FAIL rand_we0 cyc=%0d got=%b exp=%b", i, we0_o, e_we); end
            checks++; if ({addr0wr_o, data0wr_o} !== {e_addr, e_data}) begin failures++;
                $display("FAIL rand_wdata cyc=%0d got=%h/%h exp=%h/%h", i, addr0wr_o, data0wr_o, e_addr, e_data); end
            checks++; if (int'(count_o) !== e_count) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, count_o, e_count); end
            checks++; if ({rpt_ready_o, overflow_o} !== {e_ready, movf}) begin failures++;
                $display("FAIL rand_flags cyc=%0d got=%b/%b exp=%b/%b", i, rpt_ready_o, overflow_o, e_ready, movf); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_flush();
`ifdef LDVIO_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
